// File: rtl/fifo_ring.sv
// Circular-buffer FIFO, any depth >= 2, with fill level, thresholds and sticky error flags.
// One write and one read per cycle; writes refused when full unless a read frees the slot.
module fifo_ring #(
    parameter int S    = 8,
    parameter int N    = 8,
    parameter int AF   = S - 1,
    parameter int AE   = 1,
    parameter int FWFT = 1,
    localparam int L   = $clog2(S + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [N-1:0] data_in,
    input  logic         write,
    output logic         rdy_in,
    output logic [N-1:0] data_out,
    output logic         rdy_out,
    input  logic         read,
    output logic [L-1:0] level,
    output logic         almost_full,
    output logic         almost_empty,
    output logic         overflow,
    output logic         underflow
);

    localparam int P                = $clog2(S);
    localparam logic [P-1:0] LAST   = P'(S - 1);
    localparam logic [L-1:0] FULL_L = L'(S);
    localparam logic [L-1:0] AF_L   = L'(AF);
    localparam logic [L-1:0] AE_L   = L'(AE);

    logic [N-1:0] mem [S];
    logic [P-1:0] wr_ptr;
    logic [P-1:0] rd_ptr;
    logic [L-1:0] lvl;
    logic         ovf;
    logic         unf;
    logic         flush;
    logic         empty;
    logic         full;
    logic         rd_acc;
    logic         wr_acc;

    // Explicit wrap so non-power-of-two depths never index past S-1.
    function automatic logic [P-1:0] bump(input logic [P-1:0] p);
        return (p == LAST) ? '0 : p + P'(1);
    endfunction

    assign flush  = !rst_n || clear;
    assign empty  = (lvl == '0);
    assign full   = (lvl == FULL_L);
    assign rd_acc = read && !empty;
    assign wr_acc = write && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   lvl <= lvl + L'(1);
                2'b01:   lvl <= lvl - L'(1);
                default: lvl <= lvl;
            endcase
            if (write && !wr_acc) begin
                ovf <= 1'b1;
            end
            if (read && !rd_acc) begin
                unf <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            // Head is sampled before this edge's write lands, so full+simultaneous is safe.
            always_ff @(posedge clk) begin
                if (flush) begin
                    data_out <= '0;
                end else if (rd_acc) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

    assign level        = lvl;
    assign rdy_in       = !full;
    assign rdy_out      = !empty;
    assign almost_full  = (lvl >= AF_L);
    assign almost_empty = (lvl <= AE_L);
    assign overflow     = ovf;
    assign underflow    = unf;

endmodule

// File: doc/fifo_ring.md
# fifo_ring

Parametrised circular-buffer FIFO. It is the successor to the team's shift-register queue and supports any depth S ≥ 2, including non-power-of-two depths. It adds a fill-level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, a synchronous flush, and a choice of first-word-fall-through or registered read data. It sits between producer/consumer stages of differing rate inside the datapath; both sides are in one clock domain.

## Interface
- S, 8: queue depth in words; any integer ≥ 2
- N, 8: data width in bits
- AF, S-1: almost_full threshold; 1 ≤ AF ≤ S
- AE, 1: almost_empty threshold; 0 ≤ AE < S
- FWFT, 1: 1 = first-word-fall-through; 0 = registered read data
- L = $clog2(S+1): derived width of level; not overridable

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- clear  in  1  synchronous flush; active-high
- data_in  in  N  write data
- write  in  1  write request
- rdy_in  out  1  space available (level < S)
- data_out  out  N  read data
- rdy_out  out  1  data available (level > 0)
- read  in  1  read request
- level  out  L  number of stored words, 0..S
- almost_full  out  1  level ≥ AF
- almost_empty  out  1  level ≤ AE
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage: S×N register array, addressed by wr_ptr and rd_ptr. Each pointer counts 0..S-1 and wraps explicitly from S-1 to 0; power-of-two modulo is not relied on. The array itself is not reset.
- Read acceptance: rd_acc = read && level != 0.
- Write acceptance: wr_acc = write && (level < S || rd_acc). When full, a write is accepted if a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] ← data_in; wr_ptr advances.
- On rd_acc: rd_ptr advances.
- Level update: +1 for wr_acc only; -1 for rd_acc only; unchanged when both or neither occur.
- Empty with simultaneous write+read: the write is accepted, the read is rejected, underflow is set, and level becomes 1.
- overflow is set on write && !wr_acc. underflow is set on read && !rd_acc. Both hold until clear or reset.
- FWFT=1: data_out = mem[rd_ptr] combinationally when level != 0, else '0.
- FWFT=0: data_out is a register. It loads mem[rd_ptr] on rd_acc and holds otherwise.
- rdy_in, rdy_out, almost_full and almost_empty are combinational decodes of the level register.
- clear (priority over read/write, below rst_n): pointers, level, overflow and underflow go to 0; the FWFT=0 data_out register goes to '0. Requests in the clear cycle are ignored and raise no error flags.
- rst_n low: same effect as clear. Reset mid-transfer discards all contents.

## Timing
- Reset values: rdy_in=1, rdy_out=0, level=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out='0.
- Write latency: word written at edge k gives rdy_out=1 and level+1 after edge k.
  - FWFT=1: that word appears on data_out after edge k if the FIFO was empty.
- Read latency:
  - FWFT=1: the head is valid whenever rdy_out=1; read at edge k exposes the next word after edge k.
  - FWFT=0: the word popped by read at edge k appears on data_out after edge k and is held until the next accepted read.
- Throughput: one write and one read per cycle, sustained, including at full and empty boundaries (except that a read from empty is rejected).
- Pointer wrap: the cycle after wr_ptr=S-1 is accepted, wr_ptr=0; no bubble.
- No combinational path from write or read to rdy_in or rdy_out.

## Test plan
- Reset/fill/drain (S=5, N=8, FWFT=1): hold rst_n=0 for 2 cycles, then write 0x11..0x15 on 5 consecutive cycles -> level 1..5, rdy_in=0 at level 5, almost_full from level 4. Then read 5 times -> data_out 0x11..0x15 in order, level returns to 0, almost_empty=1.
- Wrap-around (S=5): 3 writes, 3 reads, then 5 writes 0xA0..0xA4 and 5 reads -> output order 0xA0..0xA4. Pointers cross S-1→0 with no lost or duplicated word.
- Full simultaneous (S=5): at level 5, write 0x77 and read in the same cycle -> level stays 5, overflow=0, head advances, 0x77 is read out last.
- Error flags: at level 5, write 0x99 alone -> overflow=1, level 5, 0x99 never read. At level 0, read -> underflow=1. Both stay set until clear pulses, then both go to 0, level=0, rdy_in=1.
- Registered mode (FWFT=0, S=4): write 0x01, 0x02; read at edge k -> data_out=0x01 after edge k, held until a read at edge k+3 gives 0x02.
- Reset mid-operation: at level 3, drive rst_n=0 together with write=1 -> after that edge level=0, rdy_out=0, data_out='0, and the write is discarded.
